// File: rtl/axi_pkg.sv
// Shared AXI definitions for the DDR3 write master (and the future read master):
// burst/size/response encodings and the write-FSM state enum.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW   = 2'd1,
        WR_W    = 2'd2,
        WR_B    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi_master_wr.sv
// AXI4 write master: one INCR burst per request, W beats fed from a FWFT FIFO.
// Optional macro AXI_WR_RESP_CHK_EN enables the sticky bad-response flag axi_wr_err.
//
// state   | meaning
// WR_IDLE | ready for a request; start latches addr/len
// WR_AW   | address phase, awvalid high until awready
// WR_W    | data phase, one FIFO pop per accepted beat, wlast on beat len
// WR_B    | waiting for the write response
module axi_master_wr
    import axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    parameter int AXI_ADDR_WIDTH = 30,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          axi_wr_start,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_wr_addr,
    input  logic [7:0]                    axi_wr_len,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_wr_data,
    output logic                          axi_writing,
    output logic                          axi_wr_ready,
    output logic                          axi_wr_done,
    output logic                          axi_wr_err,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    wr_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      w_hs;
    logic                      b_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (axi_wr_start) begin
                    addr_d  = axi_wr_addr;
                    len_d   = axi_wr_len;
                    state_d = WR_AW;
                end
            end
            WR_AW: begin
                if (m_axi_awready) begin
                    state_d = WR_W;
                end
            end
            WR_W: begin
                // Counter is cleared on the last beat so len=255 never needs a 9th bit.
                if (w_hs) begin
                    if (m_axi_wlast) begin
                        cnt_d   = '0;
                        state_d = WR_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    done_d  = 1'b1;
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        axi_wr_ready  = (state_q == WR_IDLE);
        m_axi_awvalid = (state_q == WR_AW);
        m_axi_wvalid  = (state_q == WR_W);
        m_axi_bready  = (state_q == WR_B);
        m_axi_wlast   = (state_q == WR_W) && (cnt_q == len_q);
        w_hs          = m_axi_wvalid & m_axi_wready;
        b_hs          = m_axi_bready & m_axi_bvalid;
        axi_writing   = w_hs;
        axi_wr_done   = done_q;
    end

    assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = SIZE_8B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wdata   = axi_wr_data;
    assign m_axi_wstrb   = '1;

`ifdef AXI_WR_RESP_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (b_hs && (m_axi_bresp != RESP_OKAY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign axi_wr_err = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^{m_axi_bresp, b_hs};
    assign axi_wr_err   = 1'b0;
`endif

endmodule
